// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS fetch datapath.
//   WORD_W / INSTR_W      : datapath and instruction widths
//   S_BOOT/S_FETCH/S_HOLD : fetch FSM state encodings
//   RESET_PC_DEFAULT      : default PC after reset
//   EXC_VECTOR_DEFAULT    : default redirect for a misaligned jr
//   branch_disp()         : sign-extended word offset converted to a byte displacement
package mips_pkg;

  localparam int WORD_W  = 32;
  localparam int INSTR_W = 32;

  localparam logic [1:0] S_BOOT  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_HOLD  = 2'd2;

  localparam logic [WORD_W-1:0] RESET_PC_DEFAULT   = 32'h0000_0000;
  localparam logic [WORD_W-1:0] EXC_VECTOR_DEFAULT = 32'h8000_0180;

  function automatic logic [WORD_W-1:0] branch_disp(input logic [15:0] offset);
    return {{14{offset[15]}}, offset, 2'b00};
  endfunction

endpackage

// File: rtl/adder32.sv
// 32-bit adder shared by the datapath. The carry out is discarded, so all
// sums wrap modulo 2^32.
//   a, b : operands
//   sum  : a + b (wrapped)
module adder32
  import mips_pkg::*;
(
  input  logic [WORD_W-1:0] a,
  input  logic [WORD_W-1:0] b,
  output logic [WORD_W-1:0] sum
);

  assign sum = a + b;

endmodule

// File: rtl/next_pc_sel.sv
// Next-PC target selection for the fetch stage. Purely combinational.
//   seq_sum      : pc + 4 from the sequential adder
//   branch_sum   : pc + 4 + branch displacement from the branch adder
//   branch_taken : select branch target
//   jump         : select j/jal target
//   jump_index   : 26-bit instruction index
//   jump_reg     : select jr/jalr target
//   reg_target   : register value for jr
//   next_pc      : selected target, priority jump_reg > jump > branch > seq
module next_pc_sel
  import mips_pkg::*;
(
  input  logic [WORD_W-1:0] seq_sum,
  input  logic [WORD_W-1:0] branch_sum,
  input  logic              branch_taken,
  input  logic              jump,
  input  logic [25:0]       jump_index,
  input  logic              jump_reg,
  input  logic [WORD_W-1:0] reg_target,
  output logic [WORD_W-1:0] next_pc
);

  logic [WORD_W-1:0] jump_target;
  logic [WORD_W-1:0] jr_target;
  logic              unused_jr_low;

  // Jump region comes from the delay-slot address (pc + 4), not pc itself.
  assign jump_target = {seq_sum[31:28], jump_index, 2'b00};

  // jr targets are always forced word aligned here; the misaligned-jr
  // exception, when built in, overrides this in the PC register instead.
  assign jr_target     = {reg_target[31:2], 2'b00};
  assign unused_jr_low = ^reg_target[1:0];

  always_comb begin
    next_pc = seq_sum;
    if (jump_reg)          next_pc = jr_target;
    else if (jump)         next_pc = jump_target;
    else if (branch_taken) next_pc = branch_sum;
  end

endmodule

// File: rtl/pc_fetch_unit.sv
// Program-counter stage: holds the PC, issues fetch requests with a ready
// handshake and picks the next PC among sequential/branch/jump/jr targets.
//   clk, reset          : clock (rising edge), async active-high reset
//   stall               : downstream hazard, blocks PC update
//   imem_ready          : instruction memory accepts the current request
//   branch_taken/offset : taken conditional branch and its signed word offset
//   jump/jump_index     : j/jal select and instruction index
//   jump_reg/reg_target : jr/jalr select and register target
//   pc, pc_plus4        : current fetch address and pc + 4 (link value)
//   imem_req            : fetch request valid
// Optional build macro PC_MISALIGN_EXC_EN adds epc/exc_pulse and redirects a
// misaligned jr to EXC_VECTOR instead of masking its low bits.
//
// state   | meaning
// S_BOOT  | leaving reset, no request issued
// S_FETCH | request valid, pc advances when accepted and not stalled
// S_HOLD  | request accepted under stall, waiting to advance pc
module pc_fetch_unit
  import mips_pkg::*;
#(
  parameter logic [WORD_W-1:0] RESET_PC   = RESET_PC_DEFAULT,
  parameter logic [WORD_W-1:0] EXC_VECTOR = EXC_VECTOR_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              imem_ready,
  input  logic              branch_taken,
  input  logic [15:0]       branch_offset,
  input  logic              jump,
  input  logic [25:0]       jump_index,
  input  logic              jump_reg,
  input  logic [WORD_W-1:0] reg_target,
  output logic [WORD_W-1:0] pc,
  output logic [WORD_W-1:0] pc_plus4,
`ifdef PC_MISALIGN_EXC_EN
  output logic [WORD_W-1:0] epc,
  output logic              exc_pulse,
`endif
  output logic              imem_req
);

  logic [1:0]        state;
  logic [1:0]        next_state;
  logic              pc_update;
  logic [WORD_W-1:0] disp;
  logic [WORD_W-1:0] branch_sum;
  logic [WORD_W-1:0] next_pc;

  assign disp = branch_disp(branch_offset);

  adder32 u_seq_add (
    .a   (pc),
    .b   (32'd4),
    .sum (pc_plus4)
  );

  adder32 u_branch_add (
    .a   (pc_plus4),
    .b   (disp),
    .sum (branch_sum)
  );

  next_pc_sel u_next_pc_sel (
    .seq_sum      (pc_plus4),
    .branch_sum   (branch_sum),
    .branch_taken (branch_taken),
    .jump         (jump),
    .jump_index   (jump_index),
    .jump_reg     (jump_reg),
    .reg_target   (reg_target),
    .next_pc      (next_pc)
  );

  // An accepted-but-stalled request advances pc later from S_HOLD, so each
  // accepted request advances pc exactly once.
  always_comb begin
    next_state = state;
    pc_update  = 1'b0;
    case (state)
      S_BOOT:  next_state = S_FETCH;
      S_FETCH: begin
        if (imem_ready) begin
          if (stall) next_state = S_HOLD;
          else       pc_update  = 1'b1;
        end
      end
      S_HOLD: begin
        if (!stall) begin
          pc_update  = 1'b1;
          next_state = S_FETCH;
        end
      end
      default: next_state = S_BOOT;
    endcase
  end

  assign imem_req = (state == S_FETCH);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_BOOT;
    else       state <= next_state;
  end

`ifdef PC_MISALIGN_EXC_EN
  logic jr_misaligned;

  assign jr_misaligned = jump_reg && (reg_target[1:0] != 2'b00);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc        <= RESET_PC;
      epc       <= '0;
      exc_pulse <= 1'b0;
    end else begin
      exc_pulse <= pc_update && jr_misaligned;
      if (pc_update) begin
        if (jr_misaligned) begin
          pc  <= EXC_VECTOR;
          epc <= reg_target;
        end else begin
          pc  <= next_pc;
        end
      end
    end
  end
`else
  logic [WORD_W-1:0] unused_exc_vector;

  assign unused_exc_vector = EXC_VECTOR;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)          pc <= RESET_PC;
    else if (pc_update) pc <= next_pc;
  end
`endif

endmodule

// File: tb/tb_pc_fetch_unit.sv
module tb_pc_fetch_unit;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        imem_ready;
  logic        branch_taken;
  logic [15:0] branch_offset;
  logic        jump;
  logic [25:0] jump_index;
  logic        jump_reg;
  logic [31:0] reg_target;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        imem_req;
`ifdef PC_MISALIGN_EXC_EN
  logic [31:0] epc;
  logic        exc_pulse;
`endif

  int total;
  int bad;

  localparam logic [31:0] EXC_ADDR = 32'h8000_0180;

  pc_fetch_unit dut (
    .clk           (clk),
    .reset         (reset),
    .stall         (stall),
    .imem_ready    (imem_ready),
    .branch_taken  (branch_taken),
    .branch_offset (branch_offset),
    .jump          (jump),
    .jump_index    (jump_index),
    .jump_reg      (jump_reg),
    .reg_target    (reg_target),
    .pc            (pc),
    .pc_plus4      (pc_plus4),
`ifdef PC_MISALIGN_EXC_EN
    .epc           (epc),
    .exc_pulse     (exc_pulse),
`endif
    .imem_req      (imem_req)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       nm;
    logic        stall;
    logic        ready;
    logic        br;
    logic [15:0] off;
    logic        j;
    logic [25:0] idx;
    logic        jr;
    logic [31:0] rt;
    logic [31:0] exp_pc;
    logic        exp_req;
  } vec_t;

  vec_t vq[$];

  task automatic add(input string nm, input logic s, input logic r, input logic b,
                     input logic [15:0] o, input logic jj, input logic [25:0] ix,
                     input logic jjr, input logic [31:0] t, input logic [31:0] ep,
                     input logic er);
    vec_t v;
    v.nm = nm; v.stall = s; v.ready = r; v.br = b; v.off = o; v.j = jj; v.idx = ix;
    v.jr = jjr; v.rt = t; v.exp_pc = ep; v.exp_req = er;
    vq.push_back(v);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic s, input logic r, input logic b, input logic [15:0] o,
                       input logic jj, input logic [25:0] ix, input logic jjr,
                       input logic [31:0] t);
    stall = s; imem_ready = r; branch_taken = b; branch_offset = o;
    jump = jj; jump_index = ix; jump_reg = jjr; reg_target = t;
  endtask

  // Reference: next pc computed straight from the target rules with plain arithmetic.
  function automatic logic [31:0] model_target(input logic [31:0] cur, input logic b,
      input logic [15:0] o, input logic jj, input logic [25:0] ix, input logic jjr,
      input logic [31:0] t);
    logic [31:0] p4;
    int          d;
    p4 = cur + 32'd4;
    if (jjr) return t & 32'hFFFF_FFFC;
    if (jj)  return (p4 & 32'hF000_0000) | ({6'd0, ix} * 32'd4);
    if (b) begin
      d = int'($signed(o)) * 4;
      return p4 + 32'(d);
    end
    return p4;
  endfunction

  logic [31:0] m_pc;
  logic        m_boot;
  logic        m_hold;
  logic        m_adv;
  logic [31:0] m_epc;
  logic        m_pulse;

  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b1;
    drive(0, 0, 0, 16'h0, 0, 26'h0, 0, 32'h0);

    #12;
    chk("reset_pc", pc, 32'h0);
    chk("reset_req", {31'd0, imem_req}, 32'd0);
    chk("reset_pc_plus4", pc_plus4, 32'h4);
`ifdef PC_MISALIGN_EXC_EN
    chk("reset_epc", epc, 32'h0);
    chk("reset_exc_pulse", {31'd0, exc_pulse}, 32'd0);
`endif
    @(negedge clk);
    reset = 1'b0;

    //   name            stall rdy br off       j idx         jr rt            exp_pc        req
    add("boot_exit",     0, 0, 0, 16'h0,    0, 26'h0,       0, 32'h0,         32'h0000_0000, 1);
    add("seq_4",         0, 1, 0, 16'h0,    0, 26'h0,       0, 32'h0,         32'h0000_0004, 1);
    add("seq_8",         0, 1, 0, 16'h0,    0, 26'h0,       0, 32'h0,         32'h0000_0008, 1);
    add("seq_c",         0, 1, 0, 16'h0,    0, 26'h0,       0, 32'h0,         32'h0000_000C, 1);
    add("seq_10",        0, 1, 0, 16'h0,    0, 26'h0,       0, 32'h0,         32'h0000_0010, 1);
    add("wait_1",        0, 0, 0, 16'h0,    0, 26'h0,       0, 32'h0,         32'h0000_0010, 1);
    add("wait_2_stall",  1, 0, 0, 16'h0,    0, 26'h0,       0, 32'h0,         32'h0000_0010, 1);
    add("wait_3_br",     0, 0, 1, 16'h10,   0, 26'h0,       0, 32'h0,         32'h0000_0010, 1);
    add("wait_4_stall",  1, 0, 0, 16'h0,    0, 26'h0,       0, 32'h0,         32'h0000_0010, 1);
    add("ready_14",      0, 1, 0, 16'h0,    0, 26'h0,       0, 32'h0,         32'h0000_0014, 1);
    add("jr_100",        0, 1, 0, 16'h0,    0, 26'h0,       1, 32'h100,       32'h0000_0100, 1);
    add("branch_back",   0, 1, 1, 16'hFFFE, 0, 26'h0,       0, 32'h0,         32'h0000_00FC, 1);
    add("jr_100_again",  0, 1, 0, 16'h0,    0, 26'h0,       1, 32'h100,       32'h0000_0100, 1);
    add("jump_over_br",  0, 1, 1, 16'hFFFE, 1, 26'h40,      0, 32'h0,         32'h0000_0100, 1);
    add("jr_20",         0, 1, 0, 16'h0,    0, 26'h0,       1, 32'h20,        32'h0000_0020, 1);
    add("stall_accept",  1, 1, 0, 16'h0,    0, 26'h0,       0, 32'h0,         32'h0000_0020, 0);
    add("hold_stay",     1, 0, 0, 16'h0,    0, 26'h0,       0, 32'h0,         32'h0000_0020, 0);
    add("hold_jr_400",   0, 0, 0, 16'h0,    0, 26'h0,       1, 32'h400,       32'h0000_0400, 1);
    add("jr_top",        0, 1, 0, 16'h0,    0, 26'h0,       1, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 1);
    add("seq_wrap",      0, 1, 0, 16'h0,    0, 26'h0,       0, 32'h0,         32'h0000_0000, 1);
    add("branch_wrap",   0, 1, 1, 16'hFFFE, 0, 26'h0,       0, 32'h0,         32'hFFFF_FFFC, 1);
    add("jump_region",   0, 1, 0, 16'h0,    1, 26'h3FF_FFFF, 0, 32'h0,        32'h0FFF_FFFC, 1);
`ifdef PC_MISALIGN_EXC_EN
    add("jr_misalign",   0, 1, 0, 16'h0,    0, 26'h0,       1, 32'h1002,      EXC_ADDR,      1);
`else
    add("jr_misalign",   0, 1, 0, 16'h0,    0, 26'h0,       1, 32'h1002,      32'h0000_1000, 1);
`endif
    add("jr_priority",   0, 1, 1, 16'h8,    1, 26'h5,       1, 32'h200,       32'h0000_0200, 1);

    foreach (vq[i]) begin
      drive(vq[i].stall, vq[i].ready, vq[i].br, vq[i].off, vq[i].j, vq[i].idx,
            vq[i].jr, vq[i].rt);
      @(posedge clk);
      #1;
      chk({vq[i].nm, "_pc"}, pc, vq[i].exp_pc);
      chk({vq[i].nm, "_req"}, {31'd0, imem_req}, {31'd0, vq[i].exp_req});
      chk({vq[i].nm, "_pc_plus4"}, pc_plus4, vq[i].exp_pc + 32'd4);
`ifdef PC_MISALIGN_EXC_EN
      chk({vq[i].nm, "_exc_pulse"}, {31'd0, exc_pulse}, {31'd0, vq[i].nm == "jr_misalign"});
      if (vq[i].nm == "jr_misalign" || vq[i].nm == "jr_priority")
        chk({vq[i].nm, "_epc"}, epc, 32'h1002);
`endif
      @(negedge clk);
    end

    // Reset in the middle of an outstanding request.
    drive(0, 0, 0, 16'h0, 0, 26'h0, 0, 32'h0);
    #1;
    chk("pre_reset_req", {31'd0, imem_req}, 32'd1);
    #1;
    reset = 1'b1;
    #1;
    chk("async_reset_pc", pc, 32'h0);
    chk("async_reset_req", {31'd0, imem_req}, 32'd0);
    chk("async_reset_pc_plus4", pc_plus4, 32'h4);
    @(negedge clk);
    reset = 1'b0;

    // Randomized run against the reference model.
    m_pc = 32'h0; m_boot = 1'b1; m_hold = 1'b0; m_epc = 32'h0; m_pulse = 1'b0;
    for (int n = 0; n < 400; n++) begin
      logic        s, r, b, jj, jjr;
      logic [15:0] o;
      logic [25:0] ix;
      logic [31:0] t;
      s   = ($urandom_range(0, 3) == 0);
      r   = ($urandom_range(0, 9) < 7);
      b   = ($urandom_range(0, 3) == 0);
      o   = 16'($urandom);
      jj  = ($urandom_range(0, 5) == 0);
      ix  = 26'($urandom);
      jjr = ($urandom_range(0, 5) == 0);
      t   = $urandom;
      if ($urandom_range(0, 3) != 0) t = t & 32'hFFFF_FFFC;
      drive(s, r, b, o, jj, ix, jjr, t);

      m_adv = 1'b0;
      if (m_boot) begin
        m_boot = 1'b0;
      end else if (m_hold) begin
        if (!s) begin
          m_adv  = 1'b1;
          m_hold = 1'b0;
        end
      end else if (r) begin
        if (s) m_hold = 1'b1;
        else   m_adv  = 1'b1;
      end
      m_pulse = 1'b0;
      if (m_adv) begin
`ifdef PC_MISALIGN_EXC_EN
        if (jjr && t[1:0] != 2'b00) begin
          m_pc    = EXC_ADDR;
          m_epc   = t;
          m_pulse = 1'b1;
        end else begin
          m_pc = model_target(m_pc, b, o, jj, ix, jjr, t);
        end
`else
        m_pc = model_target(m_pc, b, o, jj, ix, jjr, t);
`endif
      end

      @(posedge clk);
      #1;
      chk("rand_pc", pc, m_pc);
      chk("rand_req", {31'd0, imem_req}, {31'd0, !m_boot && !m_hold});
      chk("rand_pc_plus4", pc_plus4, m_pc + 32'd4);
`ifdef PC_MISALIGN_EXC_EN
      chk("rand_epc", epc, m_epc);
      chk("rand_exc_pulse", {31'd0, exc_pulse}, {31'd0, m_pulse});
`endif
      @(negedge clk);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
